// File: rtl/pcpi_div_ctrl_if.sv
// rtl/pcpi_div_ctrl_if.sv - PCPI bus and divider handshake signals for pcpi_div_ctrl
interface pcpi_div_ctrl_if #(
    parameter int XLEN = 32
);
    logic            pcpi_valid;
    logic [31:0]     pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    logic            div_start;
    logic            div_unsigned;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;
    logic            div_done;

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  div_q, div_r, div_done,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output div_start, div_unsigned, div_a, div_b
    );

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output div_q, div_r, div_done,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  div_start, div_unsigned, div_a, div_b
    );
endinterface

// File: rtl/pcpi_div_ctrl.sv
// rtl/pcpi_div_ctrl.sv - PCPI front-end for the serial divider with a one-entry result cache
module pcpi_div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    pcpi_div_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_RESP     = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;

    logic [2:0]      state_q, state_d;
    logic            wait_q, wait_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            start_q, start_d;
    logic            uns_q, uns_d;
    logic            rem_q, rem_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            drop_q, drop_d;
    logic            cache_vld_q, cache_vld_d;
    logic [XLEN-1:0] cache_q_q, cache_q_d;
    logic [XLEN-1:0] cache_r_q, cache_r_d;

    logic decode_hit;
    logic cache_hit;
    logic unused_insn;

    assign decode_hit = (bus.pcpi_insn[6:0] == 7'b0110011) &&
                        (bus.pcpi_insn[31:25] == 7'b0000001) &&
                        bus.pcpi_insn[14];

    // The cache key is the operand set of the last issued division; the q/r
    // selector is excluded so a DIV/REM pair shares one division.
    assign cache_hit = cache_vld_q &&
                       (bus.pcpi_rs1 == a_q) &&
                       (bus.pcpi_rs2 == b_q) &&
                       (bus.pcpi_insn[12] == uns_q);

    assign unused_insn = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7]};

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        start_d     = start_q;
        uns_d       = uns_q;
        rem_d       = rem_q;
        a_d         = a_q;
        b_d         = b_q;
        drop_d      = drop_q;
        cache_vld_d = cache_vld_q;
        cache_q_d   = cache_q_q;
        cache_r_d   = cache_r_q;

        case (state_q)
            S_IDLE: begin
                if (bus.pcpi_valid && decode_hit) begin
                    if (cache_hit) begin
                        rd_d    = bus.pcpi_insn[13] ? cache_r_q : cache_q_q;
                        state_d = S_RESP;
                    end else begin
                        a_d         = bus.pcpi_rs1;
                        b_d         = bus.pcpi_rs2;
                        uns_d       = bus.pcpi_insn[12];
                        rem_d       = bus.pcpi_insn[13];
                        start_d     = 1'b1;
                        drop_d      = 1'b0;
                        cache_vld_d = 1'b0;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!bus.pcpi_valid) drop_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.pcpi_valid) drop_d = 1'b1;
                if (bus.div_done) begin
                    cache_q_d   = bus.div_q;
                    cache_r_d   = bus.div_r;
                    cache_vld_d = 1'b1;
                    start_d     = 1'b0;
                    // An abandoned instruction still fills the cache but gets no response.
                    if (drop_q || !bus.pcpi_valid) begin
                        state_d = S_COOLDOWN;
                    end else begin
                        rd_d    = rem_q ? bus.div_r : bus.div_q;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:     state_d = S_COOLDOWN;
            S_COOLDOWN: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        wait_d  = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_RESP);
        ready_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= 1'b0;
            ready_q     <= 1'b0;
            rd_q        <= '0;
            start_q     <= 1'b0;
            uns_q       <= 1'b0;
            rem_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            drop_q      <= 1'b0;
            cache_vld_q <= 1'b0;
            cache_q_q   <= '0;
            cache_r_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            ready_q     <= ready_d;
            rd_q        <= rd_d;
            start_q     <= start_d;
            uns_q       <= uns_d;
            rem_q       <= rem_d;
            a_q         <= a_d;
            b_q         <= b_d;
            drop_q      <= drop_d;
            cache_vld_q <= cache_vld_d;
            cache_q_q   <= cache_q_d;
            cache_r_q   <= cache_r_d;
        end
    end

    assign bus.pcpi_wr      = ready_q;
    assign bus.pcpi_ready   = ready_q;
    assign bus.pcpi_rd      = rd_q;
    assign bus.pcpi_wait    = wait_q;
    assign bus.div_start    = start_q;
    assign bus.div_unsigned = uns_q;
    assign bus.div_a        = a_q;
    assign bus.div_b        = b_q;

endmodule

// File: tb/tb_pcpi_div_ctrl.sv
// tb/tb_pcpi_div_ctrl.sv - directed bench for pcpi_div_ctrl with a cycle-timed divider stand-in
module tb_pcpi_div_ctrl;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    pcpi_div_ctrl_if #(.XLEN(XLEN)) bus ();
    pcpi_div_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] div_insn(input logic [2:0] f3);
        return {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
    endfunction

    // Divider stand-in: done after a fixed number of cycles of start, held until start drops.
    function automatic logic is_special(input logic [31:0] a, input logic [31:0] b, input logic u);
        return (b == 32'd0) || (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic int m_lat(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (is_special(a, b, u)) return 2;
        return u ? 35 : 36;
    endfunction

    function automatic logic [31:0] m_q(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (is_special(a, b, u)) return a;
        if (u) return a / b;
        return $signed(a) / $signed(b);
    endfunction

    function automatic logic [31:0] m_r(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (b == 32'd0) return a;
        if (is_special(a, b, u)) return 32'd0;
        if (u) return a % b;
        return $signed(a) % $signed(b);
    endfunction

    int dcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.div_done <= 1'b0;
            bus.div_q    <= '0;
            bus.div_r    <= '0;
            dcnt         <= 0;
        end else if (!bus.div_start) begin
            bus.div_done <= 1'b0;
            dcnt         <= 0;
        end else if (!bus.div_done) begin
            if (dcnt == m_lat(bus.div_a, bus.div_b, bus.div_unsigned) - 1) begin
                bus.div_done <= 1'b1;
                bus.div_q    <= m_q(bus.div_a, bus.div_b, bus.div_unsigned);
                bus.div_r    <= m_r(bus.div_a, bus.div_b, bus.div_unsigned);
            end
            dcnt <= dcnt + 1;
        end
    end

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd, input int exp_lat);
        int   t;
        logic seen_start;
        logic got_ready;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = div_insn(f3);
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        t = 0;
        seen_start = 1'b0;
        got_ready = 1'b0;
        while (!got_ready && t < 100) begin
            @(negedge clk);
            t++;
            if (bus.div_start) seen_start = 1'b1;
            if (t == 1) check({tag, ".wait_t1"}, 32'(bus.pcpi_wait), 32'd1);
            if (t == 1 && exp_lat > 1) check({tag, ".div_a"}, bus.div_a, a);
            if (t == 5 && exp_lat > 5) check({tag, ".div_b"}, bus.div_b, b);
            if (bus.pcpi_ready) got_ready = 1'b1;
        end
        check({tag, ".latency"}, 32'(t), 32'(exp_lat));
        check({tag, ".rd"}, bus.pcpi_rd, exp_rd);
        check({tag, ".wr"}, 32'(bus.pcpi_wr), 32'd1);
        check({tag, ".start_seen"}, 32'(seen_start), 32'(exp_lat > 1));
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        check({tag, ".ready_single"}, 32'(bus.pcpi_ready), 32'd0);
        check({tag, ".wait_after"}, 32'(bus.pcpi_wait), 32'd0);
        @(negedge clk);
    endtask

    task automatic no_claim(input string tag, input logic [31:0] insn);
        logic any;
        any = 1'b0;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = 32'd100;
        bus.pcpi_rs2   = 32'd7;
        repeat (6) begin
            @(negedge clk);
            any = any | bus.pcpi_wait | bus.pcpi_ready | bus.div_start;
        end
        check({tag, ".unclaimed"}, 32'(any), 32'd0);
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".wait"}, 32'(bus.pcpi_wait), 32'd0);
        check({tag, ".ready"}, 32'(bus.pcpi_ready), 32'd0);
        check({tag, ".wr"}, 32'(bus.pcpi_wr), 32'd0);
        check({tag, ".rd"}, bus.pcpi_rd, 32'd0);
        check({tag, ".start"}, 32'(bus.div_start), 32'd0);
        check({tag, ".unsigned"}, 32'(bus.div_unsigned), 32'd0);
        check({tag, ".div_a"}, bus.div_a, 32'd0);
        check({tag, ".div_b"}, bus.div_b, 32'd0);
    endtask

    initial begin
        logic ready_seen;
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        bus.pcpi_rs1   = '0;
        bus.pcpi_rs2   = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        @(negedge clk);

        run_op("div_100_7", 3'b100, 32'd100, 32'd7, 32'd14, 38);
        run_op("rem_100_7_hit", 3'b110, 32'd100, 32'd7, 32'd2, 1);
        run_op("divu_by0", 3'b101, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 4);
        run_op("remu_by0_hit", 3'b111, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4);
        run_op("rem_ovf_hit", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_ovf_miss", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 37);

        no_claim("mul", {7'b0000001, 10'd0, 3'b000, 5'd0, 7'b0110011});
        no_claim("opimm", {7'b0000001, 10'd0, 3'b100, 5'd0, 7'b0010011});
        no_claim("xor", {7'b0000000, 10'd0, 3'b100, 5'd0, 7'b0110011});

        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 38);

        // Core abandons the instruction: no response, but the cache still fills.
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = div_insn(3'b100);
        bus.pcpi_rs1   = 32'd50;
        bus.pcpi_rs2   = 32'd5;
        repeat (5) @(negedge clk);
        bus.pcpi_valid = 1'b0;
        ready_seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            ready_seen = ready_seen | bus.pcpi_ready;
        end
        check("drop.no_ready", 32'(ready_seen), 32'd0);
        check("drop.start_low", 32'(bus.div_start), 32'd0);
        run_op("rem_50_5_hit", 3'b110, 32'd50, 32'd5, 32'd0, 1);
        run_op("div_50_5_hit", 3'b100, 32'd50, 32'd5, 32'd10, 1);

        // Reset in the middle of a division.
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = div_insn(3'b101);
        bus.pcpi_rs1   = 32'd1000;
        bus.pcpi_rs2   = 32'd10;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("div_9_3", 3'b100, 32'd9, 32'd3, 32'd3, 38);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
